// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, clocks-per-bit width and baud defaults for the UART echo loop
package uart_pkg;
  localparam int CPB_W = 16;
  localparam logic [CPB_W-1:0] CPB_DEF0 = 16'd434;
  localparam logic [CPB_W-1:0] CPB_DEF1 = 16'd217;
  localparam logic [CPB_W-1:0] CPB_DEF2 = 16'd108;
  localparam logic [CPB_W-1:0] CPB_DEF3 = 16'd868;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_ACT  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;
  function automatic logic [CPB_W-1:0] cpb_pick(
    input logic [1:0]       sel,
    input logic [CPB_W-1:0] c0,
    input logic [CPB_W-1:0] c1,
    input logic [CPB_W-1:0] c2,
    input logic [CPB_W-1:0] c3
  );
    return sel == 2'd0 ? c0 : sel == 2'd1 ? c1 : sel == 2'd2 ? c2 : c3;
  endfunction
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: DEPTH x 8 synchronous FIFO with occupancy count
// Ports: i_Clock/i_Reset (async, active-high); i_Push/i_Data write side;
//  i_Pop read side with o_Data showing the head; o_Count/o_Full/o_Empty status.
//  A push while full is accepted only when a pop happens in the same cycle.
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_Push,
  input  logic [7:0]               i_Data,
  input  logic                     i_Pop,
  output logic [7:0]               o_Data,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Full,
  output logic                     o_Empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;
  assign o_Full  = cnt_q == (AW+1)'(DEPTH);
  assign o_Empty = cnt_q == '0;
  assign o_Data  = mem_q[rd_q];
  assign o_Count = cnt_q;
  always_comb begin
    pop_ok  = i_Pop && !o_Empty;
    push_ok = i_Push && (!o_Full || pop_ok);
    mem_d   = mem_q;
    if (push_ok) mem_d[wr_q] = i_Data;
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop_ok);
    cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_loop_ctrl.sv
// uart_loop_ctrl: sequences the RX->TX echo loop through a byte FIFO and owns the shared baud divisor
// Ports: i_Clock/i_Reset (async, active-high); i_Rx_DV/i_Rx_Byte from uart_rx;
//  i_Tx_Active/i_Tx_Done from uart_tx; i_Baud_Sel requested baud; i_Clear_Err clears sticky flags;
//  o_Clocks_per_Bit to both UARTs; o_Tx_DV/o_Tx_Byte to uart_tx;
//  o_Overflow/o_Tx_Fault sticky errors; o_Fifo_Count occupancy.
module uart_loop_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned      DEPTH    = 16,
  parameter logic [CPB_W-1:0] CPB0     = CPB_DEF0,
  parameter logic [CPB_W-1:0] CPB1     = CPB_DEF1,
  parameter logic [CPB_W-1:0] CPB2     = CPB_DEF2,
  parameter logic [CPB_W-1:0] CPB3     = CPB_DEF3,
  parameter int unsigned      GAP_CLKS = 16,
  parameter int unsigned      TIMEOUT  = 4096
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Rx_DV,
  input  logic [7:0]             i_Rx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  input  logic [1:0]             i_Baud_Sel,
  input  logic                   i_Clear_Err,
  output logic [CPB_W-1:0]       o_Clocks_per_Bit,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  output logic                   o_Overflow,
  output logic                   o_Tx_Fault,
  output logic [$clog2(DEPTH):0] o_Fifo_Count
);
  localparam int TW = $clog2(TIMEOUT + GAP_CLKS) + 1;
  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [1:0]        baud_q, baud_d;
  logic [CPB_W-1:0]  cpb_q, cpb_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              ovf_q, ovf_d, fault_q, fault_d;
  logic              pop, fault_now, full, empty;
  logic [7:0]        head;
  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Push  (i_Rx_DV),
    .i_Data  (i_Rx_Byte),
    .i_Pop   (pop),
    .o_Data  (head),
    .o_Count (o_Fifo_Count),
    .o_Full  (full),
    .o_Empty (empty)
  );
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    baud_d    = baud_q;
    cpb_d     = cpb_q;
    tx_byte_d = tx_byte_q;
    pop       = 1'b0;
    fault_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          tx_byte_d = head;
          state_d   = S_START;
        end else if (i_Baud_Sel != baud_q && !i_Tx_Active) begin
          baud_d = i_Baud_Sel;
          cpb_d  = cpb_pick(i_Baud_Sel, CPB0, CPB1, CPB2, CPB3);
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT_ACT;
      end
      S_WAIT_ACT: begin
        if (i_Tx_Active) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          fault_now = 1'b1;
          timer_d   = '0;
          state_d   = S_GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (i_Tx_Done) begin
          timer_d = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == TW'(GAP_CLKS - 1)) state_d = S_IDLE;
        else timer_d = timer_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    tx_dv_d = state_d == S_START;
    // a new error in the same cycle as a clear keeps the flag set
    ovf_d   = (i_Rx_DV && full && !pop) || (ovf_q && !i_Clear_Err);
    fault_d = fault_now || (fault_q && !i_Clear_Err);
  end
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      baud_q    <= 2'd0;
      cpb_q     <= CPB0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'd0;
      ovf_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      baud_q    <= baud_d;
      cpb_q     <= cpb_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      ovf_q     <= ovf_d;
      fault_q   <= fault_d;
    end
  end
  assign o_Clocks_per_Bit = cpb_q;
  assign o_Tx_DV          = tx_dv_q;
  assign o_Tx_Byte        = tx_byte_q;
  assign o_Overflow       = ovf_q;
  assign o_Tx_Fault       = fault_q;
endmodule

// File: tb/tb_uart_loop_ctrl.sv
// tb_uart_loop_ctrl: randomized scenario bench for the UART echo-loop controller
module tb_uart_loop_ctrl;
  localparam int DEPTH = 16;
  localparam int GAP   = 16;
  localparam int TMO   = 4096;
  logic        clk = 1'b0;
  logic        rst, rx_dv, clear_err, tx_auto;
  logic [7:0]  rx_byte;
  logic [1:0]  baud_sel;
  logic        man_active, man_done, auto_active, auto_done;
  logic        tx_active, tx_done;
  logic [15:0] cpb;
  logic        tx_dv, ovf, fault;
  logic [7:0]  tx_byte;
  logic [4:0]  fcount;
  int checks = 0, failures = 0, cyc = 0, last_done_cyc = -100000, dv_double = 0;
  logic [7:0] obs_q[$];
  int         gap_q[$];
  int         dv_cyc_q[$];
  logic       prev_dv = 1'b0;
  assign tx_active = tx_auto ? auto_active : man_active;
  assign tx_done   = tx_auto ? auto_done : man_done;
  uart_loop_ctrl dut (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done), .i_Baud_Sel(baud_sel),
    .i_Clear_Err(clear_err), .o_Clocks_per_Bit(cpb), .o_Tx_DV(tx_dv),
    .o_Tx_Byte(tx_byte), .o_Overflow(ovf), .o_Tx_Fault(fault), .o_Fifo_Count(fcount)
  );
  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  // observer: every DV pulse with its byte, its cycle and the idle clocks since the last Done
  initial forever begin
    @(negedge clk);
    if (tx_done) last_done_cyc = cyc;
    if (tx_dv) begin
      obs_q.push_back(tx_byte);
      dv_cyc_q.push_back(cyc);
      gap_q.push_back(cyc - last_done_cyc - 1);
      if (prev_dv) dv_double++;
    end
    prev_dv = tx_dv;
  end
  // behavioural uart_tx: goes active 1-3 clocks after DV, stays busy 2-8 clocks, then pulses Done
  initial begin
    int d, l;
    auto_active = 1'b0;
    auto_done   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_auto && tx_dv) begin
        d = $urandom_range(1, 3);
        l = $urandom_range(2, 8);
        repeat (d) begin @(posedge clk); #1; end
        auto_active = 1'b1;
        repeat (l) begin @(posedge clk); #1; end
        auto_active = 1'b0;
        auto_done   = 1'b1;
        @(posedge clk); #1 auto_done = 1'b0;
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic wait_obs(input int target, output bit ok);
    int bud;
    bud = 0;
    while (obs_q.size() < target && bud < 20000) begin tick(); bud++; end
    ok = obs_q.size() >= target;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (cpb !== 16'd434) begin failures++; $display("FAIL reset_cpb got=%0d exp=434", cpb); end
    checks++; if (tx_dv !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", tx_dv); end
    checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", tx_byte); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (fcount !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fcount); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_latency;
    int base;
    base    = obs_q.size();
    rx_dv   = 1'b1;
    rx_byte = 8'hA5;
    tick();
    rx_dv = 1'b0;
    checks++; if (tx_dv !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", tx_dv); end
    tick();
    checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'hA5) begin failures++; $display("FAIL lat_dv got=%b/%h exp=1/a5", tx_dv, tx_byte); end
    tick();
    checks++; if (tx_dv !== 1'b0) begin failures++; $display("FAIL lat_pulse got=%b exp=0", tx_dv); end
    man_active = 1'b1;
    repeat (4) tick();
    checks++; if (tx_byte !== 8'hA5) begin failures++; $display("FAIL lat_hold got=%h exp=a5", tx_byte); end
    man_active = 1'b0;
    man_done   = 1'b1;
    tick();
    man_done = 1'b0;
    repeat (GAP + 4) tick();
    checks++; if (obs_q.size() - base !== 1) begin failures++; $display("FAIL lat_count got=%0d exp=1", obs_q.size() - base); end
  endtask
  task automatic test_burst;
    logic [7:0] exp_q[$];
    int base, n;
    bit ok;
    base    = obs_q.size();
    tx_auto = 1'b1;
    n       = $urandom_range(6, 12);
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
    for (int i = 0; i < exp_q.size(); i++) begin
      rx_dv   = 1'b1;
      rx_byte = exp_q[i];
      tick();
      rx_dv = 1'b0;
      if (i >= 5) repeat ($urandom_range(0, 3)) tick();
    end
    wait_obs(base + exp_q.size(), ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_timeout got=%0d exp=%0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      checks++; if (obs_q[base+i] !== exp_q[i]) begin failures++; $display("FAIL burst_byte%0d got=%h exp=%h", i, obs_q[base+i], exp_q[i]); end
      checks++; if (gap_q[base+i] < GAP) begin failures++; $display("FAIL burst_gap%0d got=%0d exp>=%0d", i, gap_q[base+i], GAP); end
    end
    checks++; if (dv_double !== 0) begin failures++; $display("FAIL burst_single_pulse got=%0d exp=0", dv_double); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL burst_ovf got=%b exp=0", ovf); end
    repeat (40) tick();
    tx_auto = 1'b0;
  endtask
  task automatic test_overflow;
    logic [7:0] b [DEPTH+2];
    int base, d;
    bit ok;
    base = obs_q.size();
    for (int i = 0; i < DEPTH + 2; i++) begin
      b[i]    = 8'($urandom);
      rx_dv   = 1'b1;
      rx_byte = b[i];
      tick();
    end
    rx_dv = 1'b0;
    // first byte leaves for the transmitter at once, the next DEPTH fill the FIFO, the last is dropped
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    checks++; if (fcount !== 5'(DEPTH)) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", fcount, DEPTH); end
    checks++; if (obs_q.size() <= base || obs_q[base] !== b[0]) begin failures++; $display("FAIL ovf_first_dv got=%0d exp=%h", obs_q.size() - base, b[0]); end
    d = dv_cyc_q.size() > base ? dv_cyc_q[base] : cyc;
    while (cyc < d + TMO) tick();
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL fault_early got=%b exp=0", fault); end
    tick();
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL fault_set got=%b exp=1", fault); end
    checks++; if (fcount !== 5'(DEPTH)) begin failures++; $display("FAIL fault_count got=%0d exp=%0d", fcount, DEPTH); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++; if (ovf !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL clear_err got=%b%b exp=00", ovf, fault); end
    tx_auto = 1'b1;
    wait_obs(base + 1 + DEPTH, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_drain got=%0d exp=%0d", obs_q.size() - base, DEPTH + 1); end
    for (int i = 1; i <= DEPTH && base + i < obs_q.size(); i++) begin
      checks++; if (obs_q[base+i] !== b[i]) begin failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, obs_q[base+i], b[i]); end
    end
    repeat (40) tick();
    tx_auto = 1'b0;
    checks++; if (fcount !== 5'd0) begin failures++; $display("FAIL ovf_empty got=%0d exp=0", fcount); end
  endtask
  task automatic test_baud;
    logic [7:0] exp_q[$];
    int base, bud;
    base    = obs_q.size();
    tx_auto = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'($urandom));
      rx_dv   = 1'b1;
      rx_byte = exp_q[i];
      tick();
    end
    rx_dv    = 1'b0;
    baud_sel = 2'd2;
    bud      = 0;
    while (cpb === 16'd434 && bud < 2000) begin tick(); bud++; end
    checks++; if (cpb !== 16'd108) begin failures++; $display("FAIL baud_new got=%0d exp=108", cpb); end
    checks++; if (obs_q.size() - base !== 3) begin failures++; $display("FAIL baud_after_drain got=%0d exp=3", obs_q.size() - base); end
    checks++; if (cyc - last_done_cyc - 1 < GAP) begin failures++; $display("FAIL baud_quiet got=%0d exp>=%0d", cyc - last_done_cyc - 1, GAP); end
    for (int i = 0; i < 3 && base + i < obs_q.size(); i++) begin
      checks++; if (obs_q[base+i] !== exp_q[i]) begin failures++; $display("FAIL baud_byte%0d got=%h exp=%h", i, obs_q[base+i], exp_q[i]); end
    end
    tx_auto  = 1'b0;
    baud_sel = 2'd3;
    tick();
    checks++; if (cpb !== 16'd868) begin failures++; $display("FAIL baud_idle got=%0d exp=868", cpb); end
    man_active = 1'b1;
    baud_sel   = 2'd1;
    repeat (3) tick();
    checks++; if (cpb !== 16'd868) begin failures++; $display("FAIL baud_busy_hold got=%0d exp=868", cpb); end
    man_active = 1'b0;
    tick();
    checks++; if (cpb !== 16'd217) begin failures++; $display("FAIL baud_after_busy got=%0d exp=217", cpb); end
    baud_sel = 2'd0;
    tick();
    checks++; if (cpb !== 16'd434) begin failures++; $display("FAIL baud_back got=%0d exp=434", cpb); end
  endtask
  task automatic test_reset_mid;
    int base;
    for (int i = 0; i < 5; i++) begin
      rx_dv   = 1'b1;
      rx_byte = 8'($urandom_range(1, 255));
      tick();
    end
    rx_dv      = 1'b0;
    man_active = 1'b1;
    repeat (3) tick();
    checks++; if (fcount !== 5'd4) begin failures++; $display("FAIL rst_pre_count got=%0d exp=4", fcount); end
    checks++; if (tx_byte === 8'h00) begin failures++; $display("FAIL rst_pre_byte got=%h exp=nonzero", tx_byte); end
    rst = 1'b1;
    #1;
    checks++; if (fcount !== 5'd0 || tx_dv !== 1'b0 || tx_byte !== 8'h00) begin failures++; $display("FAIL rst_mid_out got=%0d/%b/%h exp=0/0/00", fcount, tx_dv, tx_byte); end
    checks++; if (cpb !== 16'd434 || ovf !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got=%0d/%b/%b exp=434/0/0", cpb, ovf, fault); end
    tick();
    rst        = 1'b0;
    man_active = 1'b0;
    base       = obs_q.size();
    man_done   = 1'b1;
    tick();
    man_done = 1'b0;
    repeat (200) tick();
    checks++; if (obs_q.size() !== base) begin failures++; $display("FAIL rst_no_dv got=%0d exp=0", obs_q.size() - base); end
    checks++; if (fcount !== 5'd0) begin failures++; $display("FAIL rst_post_count got=%0d exp=0", fcount); end
  endtask
  task automatic test_full_pop;
    logic [7:0] b [DEPTH+1];
    logic [7:0] late;
    int base;
    bit ok;
    base = obs_q.size();
    for (int i = 0; i <= DEPTH; i++) begin
      b[i]    = 8'($urandom);
      rx_dv   = 1'b1;
      rx_byte = b[i];
      tick();
    end
    rx_dv = 1'b0;
    checks++; if (fcount !== 5'(DEPTH) || ovf !== 1'b0) begin failures++; $display("FAIL full_fill got=%0d/%b exp=%0d/0", fcount, ovf, DEPTH); end
    man_active = 1'b1;
    repeat (3) tick();
    man_active = 1'b0;
    man_done   = 1'b1;
    tick();
    man_done = 1'b0;
    // after GAP idle clocks the loop is back in idle and pops; push lands in that same cycle
    repeat (GAP) tick();
    late    = 8'($urandom);
    rx_dv   = 1'b1;
    rx_byte = late;
    tick();
    rx_dv = 1'b0;
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL full_pop_ovf got=%b exp=0", ovf); end
    checks++; if (fcount !== 5'(DEPTH)) begin failures++; $display("FAIL full_pop_count got=%0d exp=%0d", fcount, DEPTH); end
    checks++; if (tx_dv !== 1'b1 || tx_byte !== b[1]) begin failures++; $display("FAIL full_pop_dv got=%b/%h exp=1/%h", tx_dv, tx_byte, b[1]); end
    rx_dv     = 1'b1;
    rx_byte   = 8'($urandom);
    clear_err = 1'b1;
    tick();
    rx_dv = 1'b0;
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL err_wins got=%b exp=1", ovf); end
    tick();
    clear_err = 1'b0;
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", ovf); end
    man_active = 1'b1;
    repeat (3) tick();
    man_active = 1'b0;
    man_done   = 1'b1;
    tick();
    man_done = 1'b0;
    tx_auto  = 1'b1;
    wait_obs(base + DEPTH + 2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_drain got=%0d exp=%0d", obs_q.size() - base, DEPTH + 2); end
    for (int i = 0; i <= DEPTH && base + i < obs_q.size(); i++) begin
      checks++; if (obs_q[base+i] !== b[i]) begin failures++; $display("FAIL full_byte%0d got=%h exp=%h", i, obs_q[base+i], b[i]); end
    end
    checks++; if (obs_q.size() > base + DEPTH + 1 && obs_q[base+DEPTH+1] !== late) begin failures++; $display("FAIL full_late got=%h exp=%h", obs_q[base+DEPTH+1], late); end
    repeat (40) tick();
    tx_auto = 1'b0;
  endtask
  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; clear_err = 1'b0; tx_auto = 1'b0;
    baud_sel = 2'd0; man_active = 1'b0; man_done = 1'b0;
    test_reset();
    test_latency();
    test_burst();
    test_overflow();
    test_baud();
    test_full_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
